// File: rtl/counter_ctrl.sv
`default_nettype none
// counter_ctrl: prescaled ping-pong sequencer driving an up/down counter's enable/direction.
// Optional macro DWELL_EN adds a pause of DWELL pulse intervals at each turn-around.
module counter_ctrl #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 5,
    parameter int DWELL    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [WIDTH-1:0] upper_lim_i,
    input  logic [WIDTH-1:0] lower_lim_i,
    input  logic [WIDTH-1:0] counter_in_i,
    output logic             enable_o,
    output logic             direction_o,
    output logic             busy_o,
    output logic             lim_err_o
);

    localparam int            PW     = $clog2(PRESCALE);
    localparam logic [PW-1:0] TC_VAL = PW'(PRESCALE - 1);

`ifdef DWELL_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_UP    = 2'd1,
        S_DOWN  = 2'd2,
        S_DWELL = 2'd3
    } state_t;

    localparam state_t AFTER_UP   = S_DWELL;
    localparam state_t AFTER_DOWN = S_DWELL;

    localparam int             DCW        = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DCW-1:0] DWELL_LAST = DCW'(DWELL - 1);

    logic [DCW-1:0] dwell_q, dwell_d;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2
    } state_t;

    localparam state_t AFTER_UP   = S_DOWN;
    localparam state_t AFTER_DOWN = S_UP;

    logic unused_dwell;
    assign unused_dwell = ^DWELL;
`endif

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          enable_q, enable_d;
    logic          dir_q, dir_d;
    logic          busy_q, busy_d;
    logic          lim_err_q, lim_err_d;
    logic          tc;
    logic          lim_bad;

    always_comb begin
        lim_bad  = (lower_lim_i >= upper_lim_i);
        tc       = (presc_q == TC_VAL);
        state_d  = state_q;
        presc_d  = presc_q;
        enable_d = 1'b0;
        dir_d    = dir_q;
`ifdef DWELL_EN
        dwell_d  = dwell_q;
`endif

        if (stop_i) begin
            state_d = S_IDLE;
            presc_d = '0;
            dir_d   = 1'b1;
`ifdef DWELL_EN
            dwell_d = '0;
`endif
        end else if (state_q == S_IDLE) begin
            presc_d = '0;
            if (start_i) begin
                state_d = S_UP;
                dir_d   = 1'b1;
            end
        end else begin
            presc_d = tc ? '0 : presc_q + 1'b1;
            // Bad limits freeze the sequencer; the prescaler keeps running so
            // recovery lands on a regular pulse slot.
            if (tc && !lim_bad) begin
                case (state_q)
                    S_UP: begin
                        if (counter_in_i < upper_lim_i) begin
                            enable_d = 1'b1;
                            dir_d    = 1'b1;
                        end else begin
                            dir_d   = 1'b0;
                            state_d = AFTER_UP;
                        end
                    end
                    S_DOWN: begin
                        if (counter_in_i > lower_lim_i) begin
                            enable_d = 1'b1;
                            dir_d    = 1'b0;
                        end else begin
                            dir_d   = 1'b1;
                            state_d = AFTER_DOWN;
                        end
                    end
`ifdef DWELL_EN
                    S_DWELL: begin
                        // direction already points the new way
                        if (dwell_q == DWELL_LAST) begin
                            dwell_d = '0;
                            state_d = dir_q ? S_UP : S_DOWN;
                        end else begin
                            dwell_d = dwell_q + 1'b1;
                        end
                    end
`endif
                    default: begin
                        state_d = state_q;
                    end
                endcase
            end
        end

        busy_d    = (state_d != S_IDLE);
        lim_err_d = busy_d && lim_bad;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            presc_q   <= '0;
            enable_q  <= 1'b0;
            dir_q     <= 1'b1;
            busy_q    <= 1'b0;
            lim_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            enable_q  <= enable_d;
            dir_q     <= dir_d;
            busy_q    <= busy_d;
            lim_err_q <= lim_err_d;
        end
    end

`ifdef DWELL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell_q <= '0;
        end else begin
            dwell_q <= dwell_d;
        end
    end
`endif

    assign enable_o    = enable_q;
    assign direction_o = dir_q;
    assign busy_o      = busy_q;
    assign lim_err_o   = lim_err_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_ctrl.sv
`default_nettype none
// tb_counter_ctrl: directed closed-loop bench; a behavioural up/down counter closes the loop.
module tb_counter_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] upper = 8'd0;
    logic [7:0] lower = 8'd0;
    logic [7:0] cnt = 8'd0;
    logic [7:0] preset_val = 8'd0;
    logic       preset = 1'b0;
    logic       enable, direction, busy, lim_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pcyc[$];
    int pcnt[$];
    int pdir[$];

    int e_off[7] = '{6, 11, 16, 26, 31, 36, 46};
    int e_dir[7] = '{1, 1, 1, 0, 0, 0, 1};
    int e_cnt[7] = '{0, 1, 2, 3, 2, 1, 0};

    counter_ctrl #(.WIDTH(8), .PRESCALE(5), .DWELL(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .stop_i       (stop),
        .upper_lim_i  (upper),
        .lower_lim_i  (lower),
        .counter_in_i (cnt),
        .enable_o     (enable),
        .direction_o  (direction),
        .busy_o       (busy),
        .lim_err_o    (lim_err)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (preset) cnt <= preset_val;
        else if (enable) cnt <= direction ? cnt + 8'd1 : cnt - 8'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (enable === 1'b1) begin
            pcyc.push_back(cyc);
            pcnt.push_back(int'(cnt));
            pdir.push_back(int'(direction));
        end
    endtask

    task automatic run_to(input int t);
        while (cyc < t) step();
    endtask

    task automatic clear_q();
        pcyc.delete();
        pcnt.delete();
        pdir.delete();
    endtask

    function automatic int qv(input int which, input int i);
        if (pcyc.size() <= i) return -1;
        case (which)
            0: return pcyc[i];
            1: return pcnt[i];
            default: return pdir[i];
        endcase
    endfunction

    initial begin
        int k;

        // reset state
        repeat (3) step();
        chk("rst_enable", 32'(enable), 32'd0);
        chk("rst_dir", 32'(direction), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_lim_err", 32'(lim_err), 32'd0);
        rst = 1'b0;
        step();

        // ping-pong sweep 0..3
        lower = 8'd0;
        upper = 8'd3;
        preset_val = 8'd0;
        preset = 1'b1;
        step();
        preset = 1'b0;
        step();
        clear_q();
        k = cyc;
        start = 1'b1;
        step();
        chk("start_busy", 32'(busy), 32'd1);
        run_to(k + 21);
        chk("turn_dir_down", 32'(direction), 32'd0);
        run_to(k + 41);
        chk("turn_dir_up", 32'(direction), 32'd1);
        run_to(k + 47);
        chk("sweep_npulses", 32'(pcyc.size()), 32'd7);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("sweep_t%0d", i), 32'(qv(0, i)), 32'(k + e_off[i]));
            chk($sformatf("sweep_cnt%0d", i), 32'(qv(1, i)), 32'(e_cnt[i]));
            chk($sformatf("sweep_dir%0d", i), 32'(qv(2, i)), 32'(e_dir[i]));
        end
        chk("sweep_cnt_end", 32'(cnt), 32'd1);
        chk("sweep_lim_err", 32'(lim_err), 32'd0);

        // stop on pulse at counter=2 while start still high
        run_to(k + 56);
        chk("stop_pre_enable", 32'(enable), 32'd1);
        chk("stop_pre_cnt", 32'(cnt), 32'd2);
        stop = 1'b1;
        step();
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_enable", 32'(enable), 32'd0);
        chk("stop_dir", 32'(direction), 32'd1);
        chk("stop_cnt", 32'(cnt), 32'd3);
        clear_q();
        repeat (20) step();
        chk("stop_no_pulses", 32'(pcyc.size()), 32'd0);
        chk("stop_cnt_frozen", 32'(cnt), 32'd3);
        stop = 1'b0;
        start = 1'b0;
        step();

        // limit error and recovery
        lower = 8'd0;
        upper = 8'd9;
        clear_q();
        k = cyc;
        start = 1'b1;
        run_to(k + 6);
        chk("lim_first_pulse", 32'(enable), 32'd1);
        chk("lim_first_cnt", 32'(cnt), 32'd3);
        lower = 8'd5;
        upper = 8'd5;
        clear_q();
        step();
        chk("lim_err_set", 32'(lim_err), 32'd1);
        chk("lim_err_busy", 32'(busy), 32'd1);
        run_to(k + 18);
        chk("lim_no_pulses", 32'(pcyc.size()), 32'd0);
        chk("lim_err_held", 32'(lim_err), 32'd1);
        upper = 8'd9;
        step();
        chk("lim_err_clear", 32'(lim_err), 32'd0);
        run_to(k + 21);
        chk("lim_resume_n", 32'(pcyc.size()), 32'd1);
        chk("lim_resume_t", 32'(qv(0, 0)), 32'(k + 21));
        chk("lim_resume_cnt", 32'(qv(1, 0)), 32'd4);
        chk("lim_resume_dir", 32'(qv(2, 0)), 32'd1);
        stop = 1'b1;
        start = 1'b0;
        step();
        stop = 1'b0;
        step();

        // inverted limits are not an error while idle
        lower = 8'd6;
        upper = 8'd2;
        step();
        chk("idle_lim_err", 32'(lim_err), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // counter above window on entry
        lower = 8'd0;
        upper = 8'd10;
        preset_val = 8'd20;
        preset = 1'b1;
        step();
        preset = 1'b0;
        step();
        chk("out_preset", 32'(cnt), 32'd20);
        clear_q();
        k = cyc;
        start = 1'b1;
        run_to(k + 6);
        chk("out_dir_down", 32'(direction), 32'd0);
        chk("out_no_pulse", 32'(pcyc.size()), 32'd0);
        run_to(k + 17);
        chk("out_npulses", 32'(pcyc.size()), 32'd2);
        chk("out_t0", 32'(qv(0, 0)), 32'(k + 11));
        chk("out_cnt0", 32'(qv(1, 0)), 32'd20);
        chk("out_dir0", 32'(qv(2, 0)), 32'd0);
        chk("out_t1", 32'(qv(0, 1)), 32'(k + 16));
        chk("out_cnt_end", 32'(cnt), 32'd18);

        // asynchronous reset mid-sweep
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_enable", 32'(enable), 32'd0);
        chk("arst_dir", 32'(direction), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_lim_err", 32'(lim_err), 32'd0);
        start = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        clear_q();
        repeat (10) step();
        chk("arst_no_pulses", 32'(pcyc.size()), 32'd0);
        chk("arst_idle", 32'(busy), 32'd0);

`ifdef DWELL_EN
        // dwell at the upper limit
        lower = 8'd0;
        upper = 8'd2;
        preset_val = 8'd0;
        preset = 1'b1;
        step();
        preset = 1'b0;
        step();
        clear_q();
        k = cyc;
        start = 1'b1;
        run_to(k + 16);
        chk("dwell_dir", 32'(direction), 32'd0);
        chk("dwell_busy", 32'(busy), 32'd1);
        run_to(k + 35);
        chk("dwell_quiet", 32'(pcyc.size()), 32'd2);
        run_to(k + 36);
        chk("dwell_npulses", 32'(pcyc.size()), 32'd3);
        chk("dwell_t1", 32'(qv(0, 1)), 32'(k + 11));
        chk("dwell_t2", 32'(qv(0, 2)), 32'(k + 36));
        chk("dwell_cnt2", 32'(qv(1, 2)), 32'd2);
        chk("dwell_dir2", 32'(qv(2, 2)), 32'd0);
        start = 1'b0;
        stop = 1'b1;
        step();
        stop = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
